// File: rtl/seq_tx_pkg.sv
// Shared constants, state encoding and checksum helper for the seq_tx link.
// Used by the transmitter and by any receiver model that has to agree with its framing.
package seq_tx_pkg;

  localparam int         HEAD_W_DEF   = 8;
  localparam logic [7:0] HEAD_PAT_DEF = 8'hB5;
  localparam int         DATA_BYTES   = 4;
  localparam int         FRAME_BITS   = 48;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEAD = 3'd1,
    DATA = 3'd2,
    SUM  = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Sum is formed 10 bits wide; the upper bits are discarded.
  function automatic logic [7:0] seq_sum(input logic [7:0] d0, input logic [7:0] d1,
                                         input logic [7:0] d2, input logic [7:0] d3);
    logic [9:0] w_acc;
    w_acc = 10'(d0) + 10'(d1) + 10'(d2) + 10'(d3);
    return w_acc[7:0];
  endfunction

endpackage

// File: rtl/seq_tx_if.sv
// Frame request channel into seq_tx: valid/ready plus the four payload bytes.
interface seq_tx_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] data3;

  modport master (output in_valid, output data0, output data1, output data2, output data3,
                  input  in_ready);
  modport slave  (input  in_valid, input  data0, input  data1, input  data2, input  data3,
                  output in_ready);

endinterface

// File: rtl/seq_tx_shift.sv
// Load/shift register for one whole frame; the MSB flop drives the serial line.
module seq_tx_shift #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_sr;

  // Zeros shift in behind the frame, so the line falls idle on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= {r_sr[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: header, four data bytes, checksum, MSB first, then GAP_CYC idle cycles.
// Optional SEQ_TX_ERR_INJ_EN adds i_err_inj, which flips checksum bit 0 for the accepted frame.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int                HEAD_W   = HEAD_W_DEF,
  parameter logic [HEAD_W-1:0] HEAD_PAT = HEAD_W'(HEAD_PAT_DEF),
  parameter int                GAP_CYC  = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_tx_if.slave  bus,
`ifdef SEQ_TX_ERR_INJ_EN
  input  logic     i_err_inj,
`endif
  output logic     o_sout,
  output logic     o_busy,
  output logic     o_done
);

  localparam int         FRAME_W = HEAD_W + 8 * DATA_BYTES + 8;
  localparam logic [5:0] GAP_LD  = (GAP_CYC > 0) ? 6'(GAP_CYC - 1) : 6'd0;

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_cnt;
  logic [5:0]         w_cnt_next;
  logic               w_last;
  logic               w_ready;
  logic               w_accept;
  logic               w_load;
  logic               w_shift;
  logic [7:0]         w_sum;
  logic [FRAME_W-1:0] w_frame;

`ifdef SEQ_TX_ERR_INJ_EN
  assign w_sum = seq_sum(bus.data0, bus.data1, bus.data2, bus.data3) ^ {7'd0, i_err_inj};
`else
  assign w_sum = seq_sum(bus.data0, bus.data1, bus.data2, bus.data3);
`endif

  assign w_frame = {HEAD_PAT, bus.data0, bus.data1, bus.data2, bus.data3, w_sum};

  // Ready also in the final cycle before IDLE, so a held request restarts after exactly GAP_CYC zeros.
  assign w_last   = ((r_state == GAP) && (r_cnt == 6'd0)) ||
                    ((GAP_CYC == 0) && (r_state == SUM) && (r_cnt == 6'd0));
  assign w_ready  = (r_state == IDLE) || w_last;
  assign w_accept = bus.in_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    case (r_state)
      IDLE: ;
      HEAD: begin
        w_shift = 1'b1;
        if (r_cnt == 6'd0) begin
          w_next     = DATA;
          w_cnt_next = 6'(8 * DATA_BYTES - 1);
        end else begin
          w_cnt_next = r_cnt - 6'd1;
        end
      end
      DATA: begin
        w_shift = 1'b1;
        if (r_cnt == 6'd0) begin
          w_next     = SUM;
          w_cnt_next = 6'd7;
        end else begin
          w_cnt_next = r_cnt - 6'd1;
        end
      end
      SUM: begin
        w_shift = 1'b1;
        if (r_cnt == 6'd0) begin
          w_next     = (GAP_CYC > 0) ? GAP : IDLE;
          w_cnt_next = GAP_LD;
        end else begin
          w_cnt_next = r_cnt - 6'd1;
        end
      end
      GAP: begin
        if (r_cnt == 6'd0) begin
          w_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 6'd1;
        end
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 6'd0;
      end
    endcase
    if (w_accept) begin
      w_next     = HEAD;
      w_cnt_next = 6'(HEAD_W - 1);
      w_load     = 1'b1;
    end
  end

  seq_tx_shift #(.W(FRAME_W)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_frame),
    .o_msb   (o_sout)
  );

  assign bus.in_ready = w_ready;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == SUM) && (r_cnt == 6'd0);

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: one instance with GAP_CYC=2, one with GAP_CYC=0.
// Expected frames are hand-computed constants; SEQ_TX_ERR_INJ_EN adds the error-injection vectors.
module tb_seq_tx;
  import seq_tx_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sout2, busy2, done2;
  logic sout0, busy0, done0;
  int   nVec  = 0;
  int   nMiss = 0;

  logic [47:0] capSout, capDone, capReady, capBusy;

  always #5 clk = ~clk;

  seq_tx_if bus2();
  seq_tx_if bus0();

`ifdef SEQ_TX_ERR_INJ_EN
  logic errInj2;
  logic errInj0;
`endif

  seq_tx #(.GAP_CYC(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2.slave),
`ifdef SEQ_TX_ERR_INJ_EN
    .i_err_inj (errInj2),
`endif
    .o_sout    (sout2),
    .o_busy    (busy2),
    .o_done    (done2)
  );

  seq_tx #(.GAP_CYC(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0.slave),
`ifdef SEQ_TX_ERR_INJ_EN
    .i_err_inj (errInj0),
`endif
    .o_sout    (sout0),
    .o_busy    (busy0),
    .o_done    (done0)
  );

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic setBus(input bit useGap2, input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    if (useGap2) begin
      bus2.in_valid = v; bus2.data0 = a; bus2.data1 = b; bus2.data2 = c; bus2.data3 = d;
    end else begin
      bus0.in_valid = v; bus0.data0 = a; bus0.data1 = b; bus0.data2 = c; bus0.data3 = d;
    end
  endtask

  // Called at a negedge; captures the 48 cycles following the accept edge on dut2.
  task automatic applyStimulus(input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
    int waitCyc = 0;
    while (bus2.in_ready !== 1'b1 && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (waitCyc >= 200) checkOutput("readyWait", 48'(bus2.in_ready), 48'd1);
    setBus(1'b1, 1'b1, d0, d1, d2, d3);
    @(posedge clk);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) setBus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      capSout[47-k]  = sout2;
      capDone[47-k]  = done2;
      capReady[47-k] = bus2.in_ready;
      capBusy[47-k]  = busy2;
    end
  endtask

  task automatic checkGap(input string tag);
    logic [2:0] s, b, r, d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s[2-i] = sout2; b[2-i] = busy2; r[2-i] = bus2.in_ready; d[2-i] = done2;
    end
    checkOutput({tag, "GapSout"},  48'(s), 48'b000);
    checkOutput({tag, "GapBusy"},  48'(b), 48'b110);
    checkOutput({tag, "GapReady"}, 48'(r), 48'b011);
    checkOutput({tag, "GapDone"},  48'(d), 48'b000);
  endtask

  task automatic runBackToBack(input bit useGap2, input int gap, input string tag);
    logic [47:0] frameA, frameB;
    int          gapOnes = 0;
    frameA = '0;
    frameB = '0;
    setBus(useGap2, 1'b1, 8'h12, 8'h34, 8'h56, 8'h78);
    @(posedge clk);
    for (int k = 0; k < 96 + gap; k++) begin
      @(negedge clk);
      if (k == 0) setBus(useGap2, 1'b1, 8'hAA, 8'h01, 8'h10, 8'h3C);
      if (k == 48 + gap) setBus(useGap2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      if (k < 48) frameA[47-k] = useGap2 ? sout2 : sout0;
      else if (k < 48 + gap) gapOnes += int'(sout2);
      else frameB[47-(k-48-gap)] = useGap2 ? sout2 : sout0;
    end
    checkOutput({tag, "FrameA"},  frameA, 48'hB5_12345678_14);
    checkOutput({tag, "GapOnes"}, 48'(gapOnes), 48'd0);
    checkOutput({tag, "FrameB"},  frameB, 48'hB5_AA01103C_F7);
  endtask

  function automatic logic rxCheckFlag(input logic [47:0] f);
    return seq_sum(f[39:32], f[31:24], f[23:16], f[15:8]) == f[7:0];
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic doneSeen;
    logic busySeen;
    rst_n = 1'b0;
    setBus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    setBus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef SEQ_TX_ERR_INJ_EN
    errInj2 = 1'b0;
    errInj0 = 1'b0;
`endif
    #12;
    checkOutput("reset2", 48'({sout2, busy2, done2, bus2.in_ready}), 48'b0001);
    checkOutput("reset0", 48'({sout0, busy0, done0, bus0.in_ready}), 48'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78);
    checkOutput("basicSout",  capSout,  48'hB5_12345678_14);
    checkOutput("basicDone",  capDone,  48'h0000_0000_0001);
    checkOutput("basicReady", capReady, 48'h0000_0000_0000);
    checkOutput("basicBusy",  capBusy,  48'hFFFF_FFFF_FFFF);
    checkGap("basic");

    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    checkOutput("wrapFF", capSout, 48'hB5_FFFFFFFF_FC);
    checkGap("wrapFF");

    applyStimulus(8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("zeroFrame", capSout, 48'hB5_00000000_00);
    checkGap("zero");

    applyStimulus(8'hAA, 8'h01, 8'h10, 8'h3C);
    checkOutput("loopHeader",  48'(capSout[47:40]), 48'hB5);
    checkOutput("loopPayload", 48'(capSout[39:8]),  48'hAA01103C);
    checkOutput("loopFlag",    48'(rxCheckFlag(capSout)), 48'd1);
    checkOutput("loopDone",    capDone, 48'h0000_0000_0001);

`ifdef SEQ_TX_ERR_INJ_EN
    errInj2 = 1'b1;
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78);
    errInj2 = 1'b0;
    checkOutput("errInjSout", capSout, 48'hB5_12345678_15);
    checkOutput("errInjFlag", 48'(rxCheckFlag(capSout)), 48'd0);
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78);
    checkOutput("noErrSout", capSout, 48'hB5_12345678_14);
    checkOutput("noErrFlag", 48'(rxCheckFlag(capSout)), 48'd1);
`endif

    repeat (4) @(negedge clk);
    runBackToBack(1'b1, 2, "b2bGap2");
    runBackToBack(1'b0, 0, "b2bGap0");

    // Reset while bit 20 (a one for an all-FF payload) is on the line.
    repeat (6) @(negedge clk);
    setBus(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    @(posedge clk);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0) setBus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    end
    checkOutput("preResetSout", 48'(sout2), 48'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset", 48'({sout2, busy2, done2, bus2.in_ready}), 48'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 1'b0;
    busySeen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      doneSeen |= done2;
      busySeen |= busy2;
    end
    checkOutput("postResetDone", 48'(doneSeen), 48'd0);
    checkOutput("postResetBusy", 48'(busySeen), 48'd0);
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78);
    checkOutput("afterResetSout", capSout, 48'hB5_12345678_14);
    checkOutput("afterResetDone", capDone, 48'h0000_0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
